// File: rtl/nnoc_pkg.sv
// Shared constants, types and FSM state encoding for the Core result path.
package nnoc_pkg;

    localparam int ACC_W    = 32;
    localparam int Q_W      = 8;
    localparam int RB_DEPTH = 16;
    localparam int Q_MAX    = 127;
    localparam int Q_MIN    = -128;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [Q_W-1:0]   q_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUANT  = 2'd1,
        STREAM = 2'd2
    } drain_state_e;

endpackage

// File: rtl/result_drain_if.sv
// Valid/ready byte stream from the result drain towards the router.
interface result_drain_if
    import nnoc_pkg::*;
#(
    parameter int OUT_WIDTH = Q_W,
    parameter int DEPTH     = RB_DEPTH
);

    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_WIDTH-1:0]     out_data;
    logic [$clog2(DEPTH)-1:0] out_index;
    logic                     out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/result_drain_quantize_sat.sv
// Single-entry quantizer: arithmetic right shift with round-half-up, then
// saturation to the signed output range. Purely combinational.
module quantize_sat
    import nnoc_pkg::*;
#(
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = Q_W
) (
    input  logic signed [IN_W-1:0]         x,
    input  logic        [$clog2(IN_W)-1:0] s,
    output logic signed [OUT_W-1:0]        q,
    output logic                           sat
);

    localparam int SW     = $clog2(IN_W);
    localparam int QMAX_I = (2 ** (OUT_W - 1)) - 1;
    localparam int QMIN_I = -(2 ** (OUT_W - 1));
    localparam logic signed [IN_W:0] QMAX_W = (IN_W + 1)'(QMAX_I);
    localparam logic signed [IN_W:0] QMIN_W = (IN_W + 1)'(QMIN_I);

    logic signed [IN_W:0] x_ext;
    logic signed [IN_W:0] half;
    logic signed [IN_W:0] shifted;

    // Round and shift one bit wider than the input so the rounding add cannot wrap.
    always_comb begin
        x_ext   = {x[IN_W-1], x};
        half    = '0;
        shifted = x_ext;
        if (s != '0) begin
            half    = (IN_W + 1)'(1) << (s - SW'(1));
            shifted = (x_ext + half) >>> s;
        end
    end

    // Clamp the rounded value into the output range and flag when clamping occurred.
    always_comb begin
        sat = 1'b0;
        q   = shifted[OUT_W-1:0];
        if (shifted > QMAX_W) begin
            sat = 1'b1;
            q   = OUT_W'(QMAX_I);
        end else if (shifted < QMIN_W) begin
            sat = 1'b1;
            q   = OUT_W'(QMIN_I);
        end
    end

endmodule

// File: rtl/result_drain.sv
// Result drain: snapshots the accumulator array on start, quantizes all
// entries in one cycle, then streams the bytes in index order downstream.
module result_drain
    import nnoc_pkg::*;
#(
    parameter int ACCUMULATE = ACC_W,
    parameter int OUT_WIDTH  = Q_W,
    parameter int DEPTH      = RB_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [$clog2(ACCUMULATE)-1:0]  shift_amt,
    input  logic signed [ACCUMULATE-1:0]   result_buffer [DEPTH],
    output logic                           busy,
    result_drain_if.master                 out_if,
    output logic [$clog2(DEPTH):0]         sat_count,
    output logic                           done
);

    localparam int IDX_BITS   = $clog2(DEPTH);
    localparam int SHIFT_BITS = $clog2(ACCUMULATE);
    localparam int CNT_BITS   = IDX_BITS + 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

    drain_state_e state;
    drain_state_e state_next;

    logic signed [ACCUMULATE-1:0] snap   [DEPTH];
    logic        [SHIFT_BITS-1:0] shift_q;
    logic        [OUT_WIDTH-1:0]  qbuf   [DEPTH];
    logic signed [OUT_WIDTH-1:0]  q_vec  [DEPTH];
    logic        [DEPTH-1:0]      sat_vec;
    logic        [IDX_BITS-1:0]   idx;
    logic        [CNT_BITS-1:0]   sat_total;
    logic        [CNT_BITS-1:0]   sat_count_q;
    logic                         done_q;
    logic                         fire;
    logic                         accept;

    assign accept = (state == IDLE) && start;
    assign fire   = (state == STREAM) && out_if.out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_quant
        quantize_sat #(
            .IN_W  (ACCUMULATE),
            .OUT_W (OUT_WIDTH)
        ) u_quant (
            .x   (snap[g]),
            .s   (shift_q),
            .q   (q_vec[g]),
            .sat (sat_vec[g])
        );
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one quantize cycle, then stream until the last beat is taken.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = QUANT;
            QUANT:   state_next = STREAM;
            STREAM:  if (fire && (idx == LAST_IDX)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the accumulator array and shift only when a start is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) snap[i] <= '0;
            shift_q <= '0;
        end else if (accept) begin
            snap    <= result_buffer;
            shift_q <= shift_amt;
        end
    end

    // Count how many entries saturated in this snapshot.
    always_comb begin
        sat_total = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sat_total = sat_total + CNT_BITS'(sat_vec[i]);
        end
    end

    // Latch all quantized bytes and the saturation count during the QUANT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) qbuf[i] <= '0;
            sat_count_q <= '0;
        end else if (state == QUANT) begin
            for (int i = 0; i < DEPTH; i++) qbuf[i] <= q_vec[i];
            sat_count_q <= sat_total;
        end
    end

    // Beat index restarts at zero before streaming and advances on each transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (state == QUANT) begin
            idx <= '0;
        end else if (fire) begin
            idx <= idx + IDX_BITS'(1);
        end
    end

    // Done pulses in the first IDLE cycle after the last beat is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= fire && (idx == LAST_IDX);
        end
    end

    assign busy             = (state != IDLE);
    assign out_if.out_valid = (state == STREAM);
    assign out_if.out_data  = (state == STREAM) ? qbuf[idx] : '0;
    assign out_if.out_index = idx;
    assign out_if.out_last  = (state == STREAM) && (idx == LAST_IDX);
    assign sat_count        = sat_count_q;
    assign done             = done_q;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: a table of quantizer vectors plus
// hand-written multi-cycle sequences, with a beat scoreboard fed at start.
module tb_result_drain;
    import nnoc_pkg::*;

    localparam int SHIFT_W = $clog2(ACC_W);
    localparam int IDX_W   = $clog2(RB_DEPTH);

    typedef struct {
        logic [Q_W-1:0]   data;
        logic [IDX_W-1:0] index;
        logic             last;
    } beat_t;

    typedef struct {
        acc_t x;
        int   s;
        int   exp_q;
        int   exp_sat;
    } quant_vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [SHIFT_W-1:0] shift_amt;
    acc_t               result_buffer [RB_DEPTH];
    logic               busy;
    logic [IDX_W:0]     sat_count;
    logic               done;

    acc_t       stim_buf [RB_DEPTH];
    beat_t      sb [$];
    quant_vec_t tbl [17];

    int   vec_count        = 0;
    int   miscompare_count = 0;
    int   exp_sat          = 0;
    int   cyc              = 0;
    int   chk_idx          = 0;
    int   chk_q            = 0;
    int   bp_phase         = 0;
    bit   mon_on           = 1'b0;
    bit   bp_mode          = 1'b0;
    bit   chk_en           = 1'b0;
    bit   prev_stall       = 1'b0;
    bit   found            = 1'b0;

    result_drain_if out_if ();

    result_drain dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .shift_amt     (shift_amt),
        .result_buffer (result_buffer),
        .busy          (busy),
        .out_if        (out_if),
        .sat_count     (sat_count),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Reference quantizer built on floor division rather than shifts.
    function automatic int quantModel(input acc_t x, input int s, output int sat);
        longint v, d, num, r;
        v = longint'(x);
        if (s == 0) begin
            r = v;
        end else begin
            d   = longint'(1) << s;
            num = v + d / 2;
            r   = num / d;
            if ((num % d != 0) && (num < 0)) r = r - 1;
        end
        sat = 0;
        if (r > Q_MAX) begin
            r = Q_MAX; sat = 1;
        end else if (r < Q_MIN) begin
            r = Q_MIN; sat = 1;
        end
        return int'(r);
    endfunction

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Drive start with the staged buffer and push the expected beats.
    task automatic applyStimulus(input int s);
        int st, q;
        for (int i = 0; i < RB_DEPTH; i++) result_buffer[i] = stim_buf[i];
        shift_amt = SHIFT_W'(s);
        start     = 1'b1;
        exp_sat   = 0;
        for (int i = 0; i < RB_DEPTH; i++) begin
            q = quantModel(stim_buf[i], s, st);
            exp_sat += st;
            sb.push_back('{data: Q_W'(q), index: IDX_W'(i), last: (i == RB_DEPTH - 1)});
        end
    endtask

    task automatic pulseStart(input int s);
        applyStimulus(s);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc) begin
            @(negedge clk);
            n++;
            if (done) return;
        end
        checkOutput("done_seen", done, 1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"},  busy, 0);
        checkOutput({tag, "_valid"}, out_if.out_valid, 0);
        checkOutput({tag, "_last"},  out_if.out_last, 0);
        checkOutput({tag, "_done"},  done, 0);
        checkOutput({tag, "_data"},  out_if.out_data, 0);
        checkOutput({tag, "_index"}, out_if.out_index, 0);
        checkOutput({tag, "_sat"},   sat_count, 0);
    endtask

    // Downstream ready: steady level, or the 1,0,0,1 backpressure pattern.
    initial begin
        out_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_if.out_ready = ((bp_phase % 4) == 0) || ((bp_phase % 4) == 3);
                bp_phase++;
            end else begin
                out_if.out_ready = 1'b1;
            end
        end
    end

    // Beat monitor: every valid beat must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (prev_stall) checkOutput("valid_held", out_if.out_valid, 1);
                if (out_if.out_valid) begin
                    checkOutput("beat_expected", (sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        checkOutput("beat_data",  out_if.out_data,  sb[0].data);
                        checkOutput("beat_index", out_if.out_index, sb[0].index);
                        checkOutput("beat_last",  out_if.out_last,  sb[0].last);
                        if (chk_en && (sb[0].index == IDX_W'(chk_idx)))
                            checkOutput("table_q", $signed(out_if.out_data), chk_q);
                        if (out_if.out_ready) void'(sb.pop_front());
                    end
                end
                prev_stall = out_if.out_valid && !out_if.out_ready;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl = '{
            '{32'sd384,         8,    2, 0},
            '{-32'sd384,        8,   -1, 0},
            '{32'sh7FFFFFFF,    8,  127, 1},
            '{32'sh80000000,    8, -128, 1},
            '{-32'sd3,          1,   -1, 0},
            '{32'sd1,           1,    1, 0},
            '{32'sh7FFFFFFF,    1,  127, 1},
            '{32'sd127,         0,  127, 0},
            '{32'sd128,         0,  127, 1},
            '{-32'sd128,        0, -128, 0},
            '{-32'sd129,        0, -128, 1},
            '{-32'sd1,          1,    0, 0},
            '{32'sd5,           2,    1, 0},
            '{32'sd6,           2,    2, 0},
            '{-32'sd6,          2,   -1, 0},
            '{32'sh7FFFFFFF,   31,    1, 0},
            '{32'sh80000000,   31,   -1, 0}
        };

        reset     = 1'b1;
        start     = 1'b0;
        shift_amt = '0;
        for (int i = 0; i < RB_DEPTH; i++) begin
            result_buffer[i] = '0;
            stim_buf[i]      = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        mon_on = 1'b1;

        // Ramp i*256 with shift 8 gives bytes 0..15, done 18 cycles after start.
        for (int i = 0; i < RB_DEPTH; i++) stim_buf[i] = acc_t'(i * 256);
        pulseStart(8);
        waitDone(100, cyc);
        checkOutput("t1_latency", cyc, 18);
        checkOutput("t1_sat", sat_count, 0);
        checkOutput("t1_sb_drained", sb.size(), 0);
        @(negedge clk);
        checkOutput("t1_done_one_cycle", done, 0);
        checkOutput("t1_idle", busy, 0);
        checkOutput("t1_sat_hold", sat_count, 0);

        // Mixed extremes in one drain.
        for (int i = 0; i < RB_DEPTH; i++) stim_buf[i] = '0;
        stim_buf[0] = 32'sd384;
        stim_buf[1] = -32'sd384;
        stim_buf[2] = 32'sh7FFFFFFF;
        stim_buf[3] = 32'sh80000000;
        @(posedge clk);
        #1 pulseStart(8);
        waitDone(100, cyc);
        checkOutput("t2_mixed_sat", sat_count, 2);

        // Table of single-entry quantizer vectors, small non-saturating fillers elsewhere.
        for (int k = 0; k < 17; k++) begin
            for (int i = 0; i < RB_DEPTH; i++)
                stim_buf[i] = acc_t'(int'($urandom_range(0, 200)) - 100);
            stim_buf[k % RB_DEPTH] = tbl[k].x;
            chk_idx = k % RB_DEPTH;
            chk_q   = tbl[k].exp_q;
            chk_en  = 1'b1;
            @(posedge clk);
            #1 pulseStart(tbl[k].s);
            waitDone(100, cyc);
            chk_en = 1'b0;
            checkOutput("t2_table_sat", sat_count, tbl[k].exp_sat);
        end

        // Backpressure with ready toggling 1,0,0,1.
        for (int i = 0; i < RB_DEPTH; i++) stim_buf[i] = acc_t'($urandom);
        bp_phase = 0;
        bp_mode  = 1'b1;
        @(posedge clk);
        #1 pulseStart(20);
        waitDone(300, cyc);
        bp_mode = 1'b0;
        checkOutput("t3_sb_drained", sb.size(), 0);
        checkOutput("t3_sat", sat_count, exp_sat);

        // Buffer rewritten after capture and a stray start mid-stream.
        for (int i = 0; i < RB_DEPTH; i++) stim_buf[i] = acc_t'(i * 1000 - 7000);
        @(posedge clk);
        #1 pulseStart(6);
        for (int i = 0; i < RB_DEPTH; i++) result_buffer[i] = 32'sh7FFFFFFF;
        shift_amt = '0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(100, cyc);
        checkOutput("t4_sat", sat_count, exp_sat);
        checkOutput("t4_sb_drained", sb.size(), 0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("t4_no_restart", busy, 0);
        end

        // Reset while beat 7 is on the bus aborts the drain without done.
        for (int i = 0; i < RB_DEPTH; i++) stim_buf[i] = acc_t'($urandom);
        @(posedge clk);
        #1 pulseStart(10);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (out_if.out_valid && (out_if.out_index == IDX_W'(6))) found = 1'b1;
        end
        checkOutput("t5_reach_idx6", found, 1);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_on = 1'b0;
        @(negedge clk);
        checkOutput("t5_idx7_before_reset", out_if.out_index, 7);
        @(negedge clk);
        checkResetState("t5_after");
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            checkOutput("t5_no_done", done, 0);
        end
        mon_on = 1'b1;
        for (int i = 0; i < RB_DEPTH; i++) stim_buf[i] = acc_t'(i * 8 - 64);
        @(posedge clk);
        #1 pulseStart(3);
        waitDone(100, cyc);
        checkOutput("t5_fresh_latency", cyc, 18);
        checkOutput("t5_sb_drained", sb.size(), 0);

        // Back-to-back: start in the done cycle of the previous drain.
        for (int i = 0; i < RB_DEPTH; i++) stim_buf[i] = acc_t'(i);
        stim_buf[0] = 32'sh7FFFFFFF;
        stim_buf[1] = 32'sh7FFFFFFF;
        stim_buf[2] = 32'sh7FFFFFFF;
        @(posedge clk);
        #1 pulseStart(0);
        waitDone(100, cyc);
        checkOutput("t6a_sat", sat_count, 3);
        for (int i = 0; i < RB_DEPTH; i++) stim_buf[i] = acc_t'(-i);
        for (int i = 0; i < 5; i++) stim_buf[i] = 32'sh80000000;
        applyStimulus(2);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("t6_quant_valid", out_if.out_valid, 0);
        checkOutput("t6_quant_busy", busy, 1);
        @(negedge clk);
        checkOutput("t6_stream_valid", out_if.out_valid, 1);
        checkOutput("t6b_sat", sat_count, 5);
        waitDone(100, cyc);
        checkOutput("t6b_sb_drained", sb.size(), 0);

        checkOutput("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
